reg_bank_mp: RTL
================

# reg_bank_mp

Parametrised multi-read-port register bank for the MIPS datapath, succeeding the fixed 32x32 two-read/one-write bank. Adds configurable width, depth and read-port count, write-to-read bypass, hardwired-zero register 0, a pending-write scoreboard for load/multi-cycle hazards, and a sequenced bulk-clear operation. Sits in the decode stage and is written from write-back.

## Interface
- `DW`, 32, data width in bits
- `DEPTH`, 32, number of registers; power of two, ≥ 4
- `NR`, 2, number of read ports, 1..4
- `AW`, $clog2(DEPTH), address width (derived, not overridden)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ra`  in  NR*AW  read addresses; port i is `ra[i*AW +: AW]`
- `rd`  out  NR*DW  read data; port i is `rd[i*DW +: DW]`
- `rd_busy`  out  NR  port i: register has a pending write
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `wd`  in  DW  write data
- `iss_valid`  in  1  an instruction that will write `iss_addr` has issued
- `iss_addr`  in  AW  destination of the issued instruction
- `clr_req`  in  1  request bulk clear (sampled only in IDLE)
- `clr_busy`  out  1  clear sequence in progress
- `clr_done`  out  1  one-cycle pulse when the clear sequence completes

## Operation
- Reset (async, rst_n=0): all registers 0, all busy bits 0, FSM IDLE, counter 0, `clr_busy`=0, `clr_done`=0.
- Reads are combinational per port:
  - `ra`=0: `rd`=0, `rd_busy`=0.
  - `we`=1, `wa`==`ra`, `wa`≠0, FSM IDLE: `rd`=`wd` (bypass), `rd_busy`=0.
  - Otherwise: `rd`=array[`ra`], `rd_busy`=busy[`ra`].
- Write: `we`=1, `wa`≠0, FSM IDLE → array[`wa`]←`wd` and busy[`wa`]←0 at the edge. Writes to `wa`=0 are discarded.
- Scoreboard: `iss_valid`=1, `iss_addr`≠0, FSM IDLE → busy[`iss_addr`]←1. If set and clear hit the same address in one cycle, set wins.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on `clr_req`=1. At the same edge, all busy bits ←0 and counter ←1. Any `we` or `iss_valid` in that cycle is ignored.
  - CLEAR: each cycle, array[counter]←0 and counter increments. When counter==DEPTH-1, that entry is cleared, `clr_done` pulses for the next cycle, and the FSM returns to IDLE.
  - In CLEAR, `we`, `iss_valid` and `clr_req` are ignored. Reads return current array contents with no bypass and `rd_busy`=0.
- `clr_busy`=1 exactly while the FSM is in CLEAR.
- Reset asserted mid-CLEAR aborts the sequence immediately. All state returns to reset values and no `clr_done` is produced.

## Timing
- Read latency 0 cycles, combinational from `ra`, `we`, `wa`, `wd`.
- Write visible via bypass in the same cycle. Visible from the array from the next cycle.
- Busy bit visible on `rd_busy` the cycle after `iss_valid`.
- Clear sequence: `clr_req` sampled at edge T0. `clr_busy`=1 from T0 through edge T0+(DEPTH-1). `clr_done`=1 for the cycle following edge T0+(DEPTH-1). The first `we` accepted is at edge T0+DEPTH. For DEPTH=32, 31 cycles busy.
- No combinational path from `clr_req` to any output.

## Structure
- Shared package `mips_pkg`: DW and DEPTH defaults, the FSM state encoding (IDLE=1'b0, CLEAR=1'b1), and the ZERO_REG address constant.
- One natural sub-module, `reg_bank_scb`: the busy-bit vector with its set/clear/flush logic and the per-port read mux. The top level holds the array, bypass logic and clear FSM.

## Test plan
- Write sweep: write 10*k to regs 0..31 (one write per cycle), then read pairs (k, k+1) on 2 ports. Required: reg0 reads 0, regk reads 10*k; `rd_busy`=0 throughout.
- Bypass and r0: `we`=1, `wa`=5, `wd`=0xDEAD_BEEF with `ra0`=5 → `rd0`=0xDEADBEEF in the same cycle. Write 0x1234 to reg 0 → reads 0.
- Scoreboard:
  - `iss_valid`, `iss_addr`=7 → `rd_busy` for `ra`=7 is 1 next cycle.
  - Write reg 7 = 0x55 → bypass 0x55 with `rd_busy`=0 that cycle; stays 0 afterwards.
  - Simultaneous `iss_addr`=9 and `wa`=9 → busy[9]=1.
- Clear: fill all regs with 0xFFFF_FFFF, pulse `clr_req`. Required:
  - `clr_busy` high for 31 cycles and `clr_done` one pulse.
  - All regs read 0.
  - A `we` during CLEAR leaves its target unmodified (still 0 after completion).
- Reset mid-clear: assert `rst_n`=0 at cycle 10 of CLEAR → `clr_busy`=0 immediately, no `clr_done`, all regs 0, busy bits 0.
- NR=4, DW=16, DEPTH=16 instance: 4 ports read distinct regs simultaneously with correct values. Bypass works on all 4 ports for the same address.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS decode-stage register bank.
// Holds default geometry, the zero-register address and the clear FSM encoding.
package mips_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_bank_scb.sv
// Pending-write scoreboard: one busy bit per register plus per-port busy read mux.
// Set beats clear on the same address; flush wipes every bit at once.
module reg_bank_scb
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NR    = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  input  logic             rd_en,
  input  logic [NR*AW-1:0] ra,
  input  logic [NR-1:0]    byp_hit,
  output logic [NR-1:0]    rd_busy
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      // Applied after the clear so an issue to the written register stays pending.
      if (set_en) busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (rd_en && !byp_hit[i] && (ra[i*AW +: AW] != AW'(ZERO_REG))) begin
        rd_busy[i] = busy_q[ra[i*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank with write bypass, hardwired r0, pending-write
// scoreboard and a sequenced bulk clear that walks the array one entry per cycle.
module reg_bank_mp
  import mips_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NR    = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rd_busy,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    wd,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_done_q, clr_done_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          idle;
  logic          start_clr;
  logic          wr_en;
  logic          iss_en;
  logic [NR-1:0] byp_hit;

  assign idle      = (state_q == StIdle);
  assign start_clr = idle & clr_req;
  // The cycle that launches a clear drops any write or issue arriving with it.
  assign wr_en     = idle & we & (wa != AW'(ZERO_REG)) & ~clr_req;
  assign iss_en    = idle & iss_valid & (iss_addr != AW'(ZERO_REG)) & ~clr_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = AW'(1);
        end
      end
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d    = StIdle;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    for (int unsigned j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
    end
    if (wr_en) mem_d[wa] = wd;
    if (state_q == StClear) mem_d[cnt_q] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
    end
  end

  always_comb begin
    byp_hit = '0;
    rd      = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      byp_hit[i] = idle & we & (wa != AW'(ZERO_REG)) & (wa == ra[i*AW +: AW]);
      if (ra[i*AW +: AW] == AW'(ZERO_REG)) begin
        rd[i*DW +: DW] = '0;
      end else if (byp_hit[i]) begin
        rd[i*DW +: DW] = wd;
      end else begin
        rd[i*DW +: DW] = mem_q[ra[i*AW +: AW]];
      end
    end
  end

  reg_bank_scb #(
    .DEPTH (DEPTH),
    .NR    (NR)
  ) u_scb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wa),
    .flush    (start_clr),
    .rd_en    (idle),
    .ra       (ra),
    .byp_hit  (byp_hit),
    .rd_busy  (rd_busy)
  );

  assign clr_busy = ~idle;
  assign clr_done = clr_done_q;

endmodule
